input_controller: RTL and testbench



---
 rtl/input_controller_if.sv | 24 ++
 rtl/input_controller.sv | 81 ++++++++
 tb/tb_input_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/input_controller_if.sv
// Pad-side signal bundle for the NES gamepad reader: strobes out, serial data in, decoded button out.
interface input_controller_if;
  logic       button_data_in;
  logic       latch_tb;
  logic       pulse_tb;
  logic       slow_clk_tb;
  logic [3:0] button_data_out_tb;

  modport master (
    input  button_data_in,
    output latch_tb,
    output pulse_tb,
    output slow_clk_tb,
    output button_data_out_tb
  );

  modport slave (
    output button_data_in,
    input  latch_tb,
    input  pulse_tb,
    input  slow_clk_tb,
    input  button_data_out_tb
  );
endinterface

// File: rtl/input_controller.sv
// Polls a serial NES-style gamepad once per frame and publishes the highest-priority
// pressed button as a 4-bit code (0 = none, 1 = A ... 8 = Right).
module input_controller #(
  parameter int unsigned HALF_DIV    = 300,
  parameter int unsigned FRAME_SLOTS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input_controller_if.master  pad
);

  localparam int unsigned DIV_W  = 19;
  localparam int unsigned SLOT_W = $clog2(FRAME_SLOTS);
  localparam int unsigned BTN_N  = 8;
  localparam int unsigned CODE_W = 4;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_PUB  = SLOT_W'(BTN_N);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  logic [DIV_W-1:0]  div_q,     div_d;
  logic              slow_clk_q, slow_clk_d;
  logic [SLOT_W-1:0] slot_q,    slot_d;
  logic [BTN_N-1:0]  capture_q, capture_d;
  logic [CODE_W-1:0] code_q,    code_d;
  logic [CODE_W-1:0] prio_c;
  logic              div_wrap_c;
  logic              fall_tick_c;

  // State register: divider, slow clock, slot sequencer, capture and published code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      slow_clk_q <= 1'b0;
      slot_q     <= '0;
      capture_q  <= '0;
      code_q     <= '0;
    end else begin
      div_q      <= div_d;
      slow_clk_q <= slow_clk_d;
      slot_q     <= slot_d;
      capture_q  <= capture_d;
      code_q     <= code_d;
    end
  end

  // Lowest set index wins, so scan from the top and let lower bits overwrite
  always_comb begin
    prio_c = '0;
    for (int i = int'(BTN_N) - 1; i >= 0; i--) begin
      if (capture_q[i]) prio_c = CODE_W'(i + 1);
    end
  end

  // Next-state: slot advances and samples on the fall tick that ends each strobe
  always_comb begin
    div_wrap_c  = (div_q == DIV_LAST);
    fall_tick_c = div_wrap_c & slow_clk_q;
    div_d       = div_wrap_c ? '0 : div_q + DIV_W'(1);
    slow_clk_d  = slow_clk_q ^ div_wrap_c;
    slot_d      = slot_q;
    capture_d   = capture_q;
    code_d      = code_q;
    if (fall_tick_c) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_ONE;
      if (slot_q < SLOT_PUB) capture_d[slot_q[2:0]] = ~pad.button_data_in;
      if (slot_q == SLOT_PUB) code_d = prio_c;
    end
  end

  // Strobes decode registered state only: latch in slot 0, shift pulses in slots 1..8
  always_comb begin
    pad.latch_tb = slow_clk_q & (slot_q == '0);
    pad.pulse_tb = slow_clk_q & (slot_q >= SLOT_ONE) & (slot_q <= SLOT_PUB);
  end

  assign pad.slow_clk_tb        = slow_clk_q;
  assign pad.button_data_out_tb = code_q;

endmodule

// File: tb/tb_input_controller.sv
// Self-checking bench for input_controller: frame-by-frame button masks from a table,
// expected codes queued at frame start and checked on the publish edge.
module tb_input_controller;

  localparam int unsigned H     = 4;
  localparam int unsigned S     = 16;
  localparam int unsigned FRAME = 2 * H * S;
  localparam int unsigned PUB_N = 18 * H;  // edge (within a frame) that ends slot 8

  typedef struct {
    logic [7:0] mask;  // bit k = button k held low during slot k
    logic [3:0] code;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_controller_if pad ();

  input_controller #(.HALF_DIV(H), .FRAME_SLOTS(S)) dut (
    .clk   (clk),
    .reset (reset),
    .pad   (pad.master)
  );

  int         checks = 0;
  int         passes = 0;
  int         n      = 0;
  logic [3:0] exp_out;
  logic [3:0] sb[$];
  vec_t       vecs[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d after release)", name, act, exp, n);
  endtask

  // Called at a negedge: check state after edge n, drive data for edge n+1, advance
  task automatic run_cycle(input logic [7:0] mask);
    int   slot;
    logic slow;
    logic [2:0] exp_strb;
    logic [3:0] popped;
    slow     = ((n / H) % 2) == 1;
    slot     = (n / (2 * H)) % S;
    exp_strb = {slow, slow && slot == 0, slow && slot >= 1 && slot <= 8};
    check("strobes{slow,latch,pulse}",
          int'({pad.slow_clk_tb, pad.latch_tb, pad.pulse_tb}), int'(exp_strb));
    check("held_code", int'(pad.button_data_out_tb), int'(exp_out));
    pad.button_data_in = !(slot < 8 && mask[slot[2:0]]);
    @(posedge clk);
    n++;
    if (n % FRAME == PUB_N) begin
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        popped  = sb.pop_front();
        exp_out = popped;
        #1;
        check("publish", int'(pad.button_data_out_tb), int'(popped));
      end
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] mask, input logic [3:0] code);
    sb.push_back(code);
    repeat (FRAME) run_cycle(mask);
  endtask

  initial begin
    vecs[0]  = '{8'h01, 4'd1};  // A
    vecs[1]  = '{8'h02, 4'd2};  // B
    vecs[2]  = '{8'h04, 4'd3};  // Select
    vecs[3]  = '{8'h08, 4'd4};  // Start
    vecs[4]  = '{8'h10, 4'd5};  // Up
    vecs[5]  = '{8'h20, 4'd6};  // Down
    vecs[6]  = '{8'h40, 4'd7};  // Left
    vecs[7]  = '{8'h80, 4'd8};  // Right
    vecs[8]  = '{8'h90, 4'd5};  // Up + Right
    vecs[9]  = '{8'h91, 4'd1};  // A + Up + Right
    vecs[10] = '{8'h08, 4'd4};  // Start pressed ...
    vecs[11] = '{8'h00, 4'd0};  // ... then released
    vecs[12] = '{8'h60, 4'd6};  // Down + Left
    vecs[13] = '{8'hFF, 4'd1};  // everything
    vecs[14] = '{8'hFE, 4'd2};  // everything but A

    reset              = 1'b1;
    pad.button_data_in = 1'b1;
    exp_out            = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", int'({pad.slow_clk_tb, pad.latch_tb, pad.pulse_tb, pad.button_data_out_tb}), 0);
    reset = 1'b0;
    n     = 0;

    // Idle line: two frames with nothing pressed
    run_frame(8'h00, 4'd0);
    run_frame(8'h00, 4'd0);

    for (int i = 0; i < 15; i++) run_frame(vecs[i].mask, vecs[i].code);

    // Reset during pulse 4 while Down is held, after a frame publishing Select
    run_frame(8'h04, 4'd3);
    repeat (38) run_cycle(8'h20);
    check("pre_reset_pulse", int'(pad.pulse_tb), 1);
    check("pre_reset_code", int'(pad.button_data_out_tb), 3);
    reset = 1'b1;
    #1;
    check("async_reset_outputs",
          int'({pad.slow_clk_tb, pad.latch_tb, pad.pulse_tb, pad.button_data_out_tb}), 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_outputs",
          int'({pad.slow_clk_tb, pad.latch_tb, pad.pulse_tb, pad.button_data_out_tb}), 0);
    @(negedge clk);
    reset   = 1'b0;
    n       = 0;
    exp_out = 4'd0;
    sb.delete();
    run_frame(8'h20, 4'd6);
    run_frame(8'h00, 4'd0);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
